// File: rtl/hnoc_pkg.sv
// Shared constants and helpers for the HNoC PE network interface.
// Flit layout is {dest, payload} with dest in the MSBs.
package hnoc_pkg;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned dest_msb(input int unsigned dw, input int unsigned aw);
        return dw + aw - 1;
    endfunction

    function automatic int unsigned dest_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned payload_msb(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned payload_lsb();
        return 0;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hnoc_pe_interface_if.sv
// PE-side and NoC-side handshake bundle of the HNoC PE network interface.
// slave is the network interface's view, master the PE/NoC environment's view.
interface hnoc_pe_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 2
);
    logic [DataWidth-1:0]           i_tx_data;
    logic [AddrWidth-1:0]           i_tx_dest;
    logic                           i_tx_valid;
    logic                           o_tx_ready;
    logic [DataWidth+AddrWidth-1:0] o_noc_data;
    logic                           o_noc_data_valid;
    logic                           i_noc_data_ready;
    logic [DataWidth+AddrWidth-1:0] i_noc_data;
    logic                           i_noc_data_valid;
    logic                           o_noc_data_ready;
    logic [DataWidth-1:0]           o_rx_data;
    logic                           o_rx_valid;
    logic                           i_rx_ready;

    modport slave (
        input  i_tx_data, i_tx_dest, i_tx_valid, i_noc_data_ready,
        input  i_noc_data, i_noc_data_valid, i_rx_ready,
        output o_tx_ready, o_noc_data, o_noc_data_valid, o_noc_data_ready,
        output o_rx_data, o_rx_valid
    );

    modport master (
        output i_tx_data, i_tx_dest, i_tx_valid, i_noc_data_ready,
        output i_noc_data, i_noc_data_valid, i_rx_ready,
        input  o_tx_ready, o_noc_data, o_noc_data_valid, o_noc_data_ready,
        input  o_rx_data, o_rx_valid
    );
endinterface

// File: rtl/hnoc_sync_fifo.sv
// Single-clock FIFO, power-of-two depth, registered occupancy, no write bypass.
// A full FIFO refuses writes even when a read happens in the same cycle.
module hnoc_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [Width-1:0]         i_wr_data,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    output logic [Width-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [$clog2(Depth):0]   o_count
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_en, rd_en;

    assign o_wr_ready = (count_q != CntW'(Depth));
    assign o_rd_valid = (count_q != '0);
    assign o_rd_data  = mem_q[rd_ptr_q];
    assign o_count    = count_q;

    assign wr_en = i_wr_valid & o_wr_ready;
    assign rd_en = o_rd_valid & i_rd_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d = count_q + CntW'(wr_en) - CntW'(rd_en);
    end

    // Storage is cleared on reset so the head reads 0 while empty.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= i_wr_data;
        end
    end
endmodule

// File: rtl/hnoc_pe_interface.sv
// Network interface between one PE and one HNoC port: TX/RX buffering,
// local loopback for self-addressed packets, misroute drop, and traffic counters.
module hnoc_pe_interface
    import hnoc_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 2,
    parameter int unsigned MyAddr    = 0,
    parameter int unsigned FifoDepth = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    hnoc_pe_if.slave         bus,
    input  logic             i_clr_count,
    output logic [CNT_W-1:0] o_tx_count,
    output logic [CNT_W-1:0] o_rx_count,
    output logic [CNT_W-1:0] o_misroute_count
);
    localparam int unsigned FlitW   = DataWidth + AddrWidth;
    localparam int unsigned OccW    = $clog2(FifoDepth) + 1;
    localparam int unsigned DestMsb = dest_msb(DataWidth, AddrWidth);
    localparam int unsigned DestLsb = dest_lsb(DataWidth);
    localparam int unsigned PayMsb  = payload_msb(DataWidth);
    localparam int unsigned PayLsb  = payload_lsb();
    localparam logic [AddrWidth-1:0] MyAddrL = AddrWidth'(MyAddr);

    logic                 tx_is_local, noc_is_local;
    logic                 tx_wr_valid, tx_wr_ready;
    logic                 rx_wr_valid, rx_wr_ready;
    logic [DataWidth-1:0] rx_wr_data;
    logic                 misroute;
    logic [OccW-1:0]      tx_occ, rx_occ;
    logic                 unused_occ;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, mis_cnt_q, mis_cnt_d;

    assign tx_is_local  = (bus.i_tx_dest == MyAddrL);
    assign noc_is_local = (bus.i_noc_data[DestMsb:DestLsb] == MyAddrL);
    assign tx_wr_valid  = bus.i_tx_valid & ~tx_is_local;

    // NoC arrivals own the RX write port; loopback only gets idle cycles.
    assign bus.o_noc_data_ready = rx_wr_ready;
    assign bus.o_tx_ready = tx_is_local ? (rx_wr_ready & ~bus.i_noc_data_valid) : tx_wr_ready;
    assign misroute = bus.i_noc_data_valid & rx_wr_ready & ~noc_is_local;

    always_comb begin
        rx_wr_valid = bus.i_tx_valid & tx_is_local;
        rx_wr_data  = bus.i_tx_data;
        if (bus.i_noc_data_valid) begin
            rx_wr_valid = noc_is_local;
            rx_wr_data  = bus.i_noc_data[PayMsb:PayLsb];
        end
    end

    hnoc_sync_fifo #(.Width(FlitW), .Depth(FifoDepth)) u_tx_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_data  ({bus.i_tx_dest, bus.i_tx_data}),
        .i_wr_valid (tx_wr_valid),
        .o_wr_ready (tx_wr_ready),
        .o_rd_data  (bus.o_noc_data),
        .o_rd_valid (bus.o_noc_data_valid),
        .i_rd_ready (bus.i_noc_data_ready),
        .o_count    (tx_occ)
    );

    hnoc_sync_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_rx_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_data  (rx_wr_data),
        .i_wr_valid (rx_wr_valid),
        .o_wr_ready (rx_wr_ready),
        .o_rd_data  (bus.o_rx_data),
        .o_rd_valid (bus.o_rx_valid),
        .i_rd_ready (bus.i_rx_ready),
        .o_count    (rx_occ)
    );

    // Occupancy is a debug tap only; fold it so it is not left dangling.
    assign unused_occ = ^{tx_occ, rx_occ};

    // Clear wins over any same-cycle increment.
    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (i_clr_count) begin
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (bus.o_noc_data_valid & bus.i_noc_data_ready) tx_cnt_d = tx_cnt_q + CNT_W'(1);
            if (bus.o_rx_valid & bus.i_rx_ready)             rx_cnt_d = rx_cnt_q + CNT_W'(1);
            if (misroute)                                    mis_cnt_d = sat_inc(mis_cnt_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign o_tx_count       = tx_cnt_q;
    assign o_rx_count       = rx_cnt_q;
    assign o_misroute_count = mis_cnt_q;
endmodule

// File: tb/tb_hnoc_pe_interface.sv
// Directed scoreboard bench for hnoc_pe_interface (MyAddr=0, depth 4).
module tb_hnoc_pe_interface;
    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [15:0] tx_cnt, rx_cnt, mis_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [33:0] tx_exp [$];
    logic [31:0] rx_exp [$];
    logic [15:0] m_tx, m_rx, m_mis;

    hnoc_pe_if #(.DataWidth(32), .AddrWidth(2)) bus ();

    hnoc_pe_interface #(.DataWidth(32), .AddrWidth(2), .MyAddr(0), .FifoDepth(4)) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .bus              (bus),
        .i_clr_count      (clr),
        .o_tx_count       (tx_cnt),
        .o_rx_count       (rx_cnt),
        .o_misroute_count (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_tx_count"},  64'(tx_cnt),  64'(m_tx));
        chk({tag, "_rx_count"},  64'(rx_cnt),  64'(m_rx));
        chk({tag, "_mis_count"}, 64'(mis_cnt), 64'(m_mis));
    endtask

    // Called just after a negedge with inputs driven: scores this cycle's handshakes, then advances.
    task automatic cycle();
        logic [33:0] ef;
        logic [31:0] ep;
        #1;
        if (bus.o_noc_data_valid && bus.i_noc_data_ready) begin
            if (tx_exp.size() == 0) chk("tx_spurious", 64'(bus.o_noc_data_valid), 64'(0));
            else begin
                ef = tx_exp.pop_front();
                chk("tx_flit", 64'(bus.o_noc_data), 64'(ef));
            end
            m_tx++;
        end
        if (bus.o_rx_valid && bus.i_rx_ready) begin
            if (rx_exp.size() == 0) chk("rx_spurious", 64'(bus.o_rx_valid), 64'(0));
            else begin
                ep = rx_exp.pop_front();
                chk("rx_payload", 64'(bus.o_rx_data), 64'(ep));
            end
            m_rx++;
        end
        if (bus.i_tx_valid && bus.o_tx_ready) begin
            if (bus.i_tx_dest == 2'd0) rx_exp.push_back(bus.i_tx_data);
            else                       tx_exp.push_back({bus.i_tx_dest, bus.i_tx_data});
        end
        if (bus.i_noc_data_valid && bus.o_noc_data_ready) begin
            if (bus.i_noc_data[33:32] == 2'd0) rx_exp.push_back(bus.i_noc_data[31:0]);
            else if (m_mis != 16'hFFFF)        m_mis++;
        end
        if (clr) begin
            m_tx = '0; m_rx = '0; m_mis = '0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_tx_valid       = 1'b0;
        bus.i_noc_data_valid = 1'b0;
        clr                  = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (tx_exp.size() == 0 && rx_exp.size() == 0) break;
            cycle();
        end
        chk({tag, "_tx_left"}, 64'(tx_exp.size()), 64'(0));
        chk({tag, "_rx_left"}, 64'(rx_exp.size()), 64'(0));
    endtask

    initial begin
        m_tx = '0; m_rx = '0; m_mis = '0;
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.i_tx_data = '0; bus.i_tx_dest = '0; bus.i_tx_valid = 1'b0;
        bus.i_noc_data_ready = 1'b0;
        bus.i_noc_data = '0; bus.i_noc_data_valid = 1'b0;
        bus.i_rx_ready = 1'b0;

        // Reset state
        @(posedge clk); @(negedge clk); #1;
        chk("rst_noc_valid", 64'(bus.o_noc_data_valid), 64'(0));
        chk("rst_rx_valid",  64'(bus.o_rx_valid),       64'(0));
        chk("rst_tx_ready",  64'(bus.o_tx_ready),       64'(1));
        chk("rst_noc_ready", 64'(bus.o_noc_data_ready), 64'(1));
        chk("rst_noc_data",  64'(bus.o_noc_data),       64'(0));
        chk("rst_rx_data",   64'(bus.o_rx_data),        64'(0));
        chk("rst_tx_count",  64'(tx_cnt),               64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic TX to dest 2
        bus.i_noc_data_ready = 1'b1;
        bus.i_rx_ready       = 1'b1;
        bus.i_tx_valid = 1'b1; bus.i_tx_dest = 2'd2; bus.i_tx_data = 32'hDEADBEEF;
        #1 chk("tx_basic_ready", 64'(bus.o_tx_ready), 64'(1));
        cycle();
        idle_inputs();
        #1;
        chk("tx_basic_valid", 64'(bus.o_noc_data_valid), 64'(1));
        chk("tx_basic_data",  64'(bus.o_noc_data),       64'({2'b10, 32'hDEADBEEF}));
        cycle();
        chk("tx_basic_count", 64'(tx_cnt), 64'(1));
        check_counts("tx_basic");

        // TX backpressure: 4 fit, the 5th is refused
        bus.i_noc_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_tx_valid = 1'b1; bus.i_tx_dest = 2'd1; bus.i_tx_data = 32'h100 + 32'(i);
            #1 chk("tx_full_ready", 64'(bus.o_tx_ready), (i < 4) ? 64'(1) : 64'(0));
            cycle();
        end
        idle_inputs();
        #1 chk("tx_stall_head", 64'(bus.o_noc_data), 64'({2'b01, 32'h100}));
        bus.i_noc_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("tx_burst_valid", 64'(bus.o_noc_data_valid), 64'(1));
            cycle();
        end
        chk("tx_burst_left", 64'(tx_exp.size()), 64'(0));
        chk("tx_burst_count", 64'(tx_cnt), 64'(5));
        check_counts("tx_burst");

        // RX delivery and misroute drop
        bus.i_noc_data_valid = 1'b1; bus.i_noc_data = {2'd0, 32'h11};
        cycle();
        bus.i_noc_data = {2'd3, 32'h22};
        cycle();
        idle_inputs();
        drain("rx_mis", 10);
        chk("rx_mis_rx_count", 64'(rx_cnt),  64'(1));
        chk("rx_mis_mis_count", 64'(mis_cnt), 64'(1));

        // Loopback loses the RX port to a same-cycle NoC arrival
        bus.i_rx_ready = 1'b0;
        bus.i_tx_valid = 1'b1; bus.i_tx_dest = 2'd0; bus.i_tx_data = 32'h55;
        bus.i_noc_data_valid = 1'b1; bus.i_noc_data = {2'd0, 32'h66};
        #1;
        chk("lb_tx_ready_blocked", 64'(bus.o_tx_ready),       64'(1'b0));
        chk("lb_noc_ready",        64'(bus.o_noc_data_ready), 64'(1));
        cycle();
        bus.i_noc_data_valid = 1'b0;
        #1 chk("lb_tx_ready_free", 64'(bus.o_tx_ready), 64'(1));
        cycle();
        idle_inputs();
        #1 chk("lb_head", 64'(bus.o_rx_data), 64'(32'h66));
        bus.i_rx_ready = 1'b1;
        drain("lb", 10);
        check_counts("lb");

        // RX full: 4 arrivals fit, the 5th is refused
        bus.i_rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_noc_data_valid = 1'b1; bus.i_noc_data = {2'd0, 32'h200 + 32'(i)};
            #1 chk("rx_full_ready", 64'(bus.o_noc_data_ready), (i < 4) ? 64'(1) : 64'(0));
            cycle();
        end
        idle_inputs();
        bus.i_rx_ready = 1'b1;
        drain("rx_full", 10);
        check_counts("rx_full");

        // Misroute counter saturates
        bus.i_noc_data_valid = 1'b1; bus.i_noc_data = {2'd3, 32'hBAD};
        for (int i = 0; i < 65536; i++) cycle();
        chk("sat_mis_count", 64'(mis_cnt), 64'(16'hFFFF));
        check_counts("sat");

        // Clear wins over a coincident misroute
        clr = 1'b1;
        cycle();
        idle_inputs();
        #1;
        chk("clr_mis_count", 64'(mis_cnt), 64'(0));
        chk("clr_tx_count",  64'(tx_cnt),  64'(0));
        chk("clr_rx_count",  64'(rx_cnt),  64'(0));

        // Reset with 3 entries buffered in each direction
        bus.i_noc_data_ready = 1'b0;
        bus.i_rx_ready       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_tx_valid = 1'b1; bus.i_tx_dest = 2'd2; bus.i_tx_data = 32'h300 + 32'(i);
            bus.i_noc_data_valid = 1'b1; bus.i_noc_data = {2'd0, 32'h400 + 32'(i)};
            cycle();
        end
        idle_inputs();
        #1;
        chk("pre_rst_noc_valid", 64'(bus.o_noc_data_valid), 64'(1));
        chk("pre_rst_rx_valid",  64'(bus.o_rx_valid),       64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_noc_valid", 64'(bus.o_noc_data_valid), 64'(0));
        chk("arst_rx_valid",  64'(bus.o_rx_valid),       64'(0));
        chk("arst_tx_ready",  64'(bus.o_tx_ready),       64'(1));
        chk("arst_noc_ready", 64'(bus.o_noc_data_ready), 64'(1));
        chk("arst_tx_count",  64'(tx_cnt),               64'(0));
        chk("arst_rx_count",  64'(rx_cnt),               64'(0));
        tx_exp.delete(); rx_exp.delete();
        m_tx = '0; m_rx = '0; m_mis = '0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        bus.i_noc_data_ready = 1'b1;
        bus.i_rx_ready       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_noc_valid", 64'(bus.o_noc_data_valid), 64'(0));
            chk("post_rst_rx_valid",  64'(bus.o_rx_valid),       64'(0));
            cycle();
        end
        check_counts("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
